// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator with periodic, one-shot and N-pulse burst modes.
// Period/width loads land in a shadow copy and only become effective at a period boundary.
module pulse_train_gen #(
  parameter int WIDTH          = 27,
  parameter int DEFAULT_PERIOD = 100_000_000,
  parameter int DEFAULT_HIGH   = 1,
  parameter int BURST_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               trigger,
  input  logic               load,
  input  logic [WIDTH-1:0]   period_in,
  input  logic [WIDTH-1:0]   high_in,
  input  logic [BURST_W-1:0] burst_in,
  output logic               pulse,
  output logic               busy,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0]   DEF_P = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0]   DEF_H = WIDTH'(DEFAULT_HIGH);
  localparam logic [BURST_W-1:0] ONE_N = BURST_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;
  logic               periodic_q, periodic_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;

  logic [WIDTH-1:0]   eff_period_q, eff_period_d;
  logic [WIDTH-1:0]   eff_high_q, eff_high_d;
  logic [BURST_W-1:0] eff_burst_q, eff_burst_d;
  logic [WIDTH-1:0]   sh_period_q, sh_period_d;
  logic [WIDTH-1:0]   sh_high_q, sh_high_d;
  logic [BURST_W-1:0] sh_burst_q, sh_burst_d;

  logic [WIDTH-1:0]   san_period;
  logic [WIDTH-1:0]   san_high;
  logic [BURST_W-1:0] san_burst;
  logic [WIDTH:0]     cnt_inc_wide;
  logic               wrap;
  logic               start;

  // Clamp loaded values so the counter always has a legal high and low phase.
  always_comb begin
    san_period = period_in;
    if (period_in < WIDTH'(2)) begin
      san_period = WIDTH'(2);
    end
    san_high = high_in;
    if (high_in == '0) begin
      san_high = WIDTH'(1);
    end else if (high_in >= san_period) begin
      san_high = san_period - WIDTH'(1);
    end
    san_burst = burst_in;
    if (burst_in == '0) begin
      san_burst = ONE_N;
    end
  end

  always_comb begin
    sh_period_d = sh_period_q;
    sh_high_d   = sh_high_q;
    sh_burst_d  = sh_burst_q;
    if (load) begin
      sh_period_d = san_period;
      sh_high_d   = san_high;
      sh_burst_d  = san_burst;
    end
  end

  assign wrap         = (cnt_q == (eff_period_q - WIDTH'(1)));
  assign cnt_inc_wide = {1'b0, cnt_q} + (WIDTH + 1)'(1);
  assign start        = (mode == 2'b00) || trigger;

  // Effective values follow the shadow (including a same-cycle load) whenever
  // the generator is idle or crosses a period boundary, so no period is cut short.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pulse_d      = pulse_q;
    done_d       = 1'b0;
    periodic_d   = periodic_q;
    remaining_d  = remaining_q;
    eff_period_d = eff_period_q;
    eff_high_d   = eff_high_q;
    eff_burst_d  = eff_burst_q;

    if (!enable) begin
      state_d      = IDLE;
      cnt_d        = '0;
      pulse_d      = 1'b0;
      eff_period_d = sh_period_d;
      eff_high_d   = sh_high_d;
      eff_burst_d  = sh_burst_d;
    end else begin
      case (state_q)
        IDLE: begin
          eff_period_d = sh_period_d;
          eff_high_d   = sh_high_d;
          eff_burst_d  = sh_burst_d;
          pulse_d      = 1'b0;
          if (start) begin
            state_d     = RUN;
            cnt_d       = '0;
            pulse_d     = 1'b1;
            periodic_d  = (mode == 2'b00);
            remaining_d = (mode == 2'b10) ? sh_burst_d : ONE_N;
          end
        end
        RUN: begin
          if (wrap) begin
            eff_period_d = sh_period_d;
            eff_high_d   = sh_high_d;
            eff_burst_d  = sh_burst_d;
            cnt_d        = '0;
            if (periodic_q || (remaining_q > ONE_N)) begin
              pulse_d = 1'b1;
              if (!periodic_q) begin
                remaining_d = remaining_q - ONE_N;
              end
            end else begin
              state_d = IDLE;
              pulse_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d   = cnt_inc_wide[WIDTH-1:0];
            pulse_d = (cnt_inc_wide < {1'b0, eff_high_q});
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          pulse_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
      done_q       <= 1'b0;
      periodic_q   <= 1'b0;
      remaining_q  <= '0;
      eff_period_q <= DEF_P;
      eff_high_q   <= DEF_H;
      eff_burst_q  <= ONE_N;
      sh_period_q  <= DEF_P;
      sh_high_q    <= DEF_H;
      sh_burst_q   <= ONE_N;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
      done_q       <= done_d;
      periodic_q   <= periodic_d;
      remaining_q  <= remaining_d;
      eff_period_q <= eff_period_d;
      eff_high_q   <= eff_high_d;
      eff_burst_q  <= eff_burst_d;
      sh_period_q  <= sh_period_d;
      sh_high_q    <= sh_high_d;
      sh_burst_q   <= sh_burst_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

  // The counter must never run past the active period.
  a_cnt_in_range: assert property (@(posedge clk) disable iff (!reset)
    (state_q == RUN) |-> (cnt_q < eff_period_q));

  a_done_idle: assert property (@(posedge clk) disable iff (!reset)
    done_q |-> (state_q == IDLE));

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: expected {pulse,busy,done} is queued with each
// stimulus cycle and compared just after the clock edge that acts on it.
module tb_pulse_train_gen;

  localparam int WIDTH   = 27;
  localparam int BURST_W = 8;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } sb_t;

  logic               clk;
  logic               reset;
  logic               enable;
  logic [1:0]         mode;
  logic               trigger;
  logic               load;
  logic [WIDTH-1:0]   period_in;
  logic [WIDTH-1:0]   high_in;
  logic [BURST_W-1:0] burst_in;
  logic               pulse;
  logic               busy;
  logic               done;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  pulse_train_gen #(
    .WIDTH(WIDTH),
    .DEFAULT_PERIOD(10),
    .DEFAULT_HIGH(1),
    .BURST_W(BURST_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .trigger(trigger),
    .load(load),
    .period_in(period_in),
    .high_in(high_in),
    .burst_in(burst_in),
    .pulse(pulse),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic en, input logic [1:0] md,
                               input logic trig, input logic ld, input int p, input int h,
                               input int n, input logic [2:0] exp);
    sb_t e;
    @(negedge clk);
    #1;
    enable  = en;
    mode    = md;
    trigger = trig;
    load    = ld;
    if (ld) begin
      period_in = WIDTH'(p);
      high_in   = WIDTH'(h);
      burst_in  = BURST_W'(n);
    end
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Expected waveform straight from the definition: high for h cycles, low for p-h.
  task automatic runPeriods(input string tag, input logic [1:0] md, input int p, input int h,
                            input int periods, input logic trig);
    for (int k = 0; k < periods; k++) begin
      for (int c = 0; c < p; c++) begin
        applyStimulus(tag, 1'b1, md, (k == 0 && c == 0) ? trig : 1'b0, 1'b0, 0, 0, 0,
                      {(c < h), 1'b1, 1'b0});
      end
    end
  endtask

  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e.tag, {29'd0, pulse, busy, done}, {29'd0, e.exp});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    mode      = 2'b00;
    trigger   = 1'b0;
    load      = 1'b0;
    period_in = '0;
    high_in   = '0;
    burst_in  = '0;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("reset_state", {29'd0, pulse, busy, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    applyStimulus("idle_disabled", 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // Defaults: P=10, H=1 free running
    runPeriods("t1_default", 2'b00, 10, 1, 2, 1'b0);
    applyStimulus("t1_third_edge", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    applyStimulus("t1_stop", 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // P=5,H=2 then a mid-run load of P=4,H=3 that must wait for the boundary
    applyStimulus("t2_load", 1'b0, 2'b00, 1'b0, 1'b1, 5, 2, 1, 3'b000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus("t2_p5h2", 1'b1, 2'b00, 1'b0, (i == 7), 4, 3, 1,
                    {((i % 5) < 2), 1'b1, 1'b0});
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus("t2_p4h3", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0,
                    {((i % 4) < 3), 1'b1, 1'b0});
    end
    applyStimulus("t2_stop", 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // Burst of 3, with an ignored trigger and mode change mid-run
    applyStimulus("t3_load", 1'b1, 2'b10, 1'b0, 1'b1, 4, 1, 3, 3'b000);
    for (int i = 0; i < 12; i++) begin
      applyStimulus("t3_burst", 1'b1, (i == 2 || i == 3) ? 2'b00 : 2'b10,
                    (i == 0 || i == 6), 1'b0, 0, 0, 0, {((i % 4) < 1), 1'b1, 1'b0});
    end
    applyStimulus("t3_done", 1'b1, 2'b10, 1'b0, 1'b0, 0, 0, 0, 3'b001);
    // Re-trigger a one-shot while done is high
    applyStimulus("t3_retrig", 1'b1, 2'b01, 1'b1, 1'b0, 0, 0, 0, 3'b110);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("t3_oneshot", 1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 0, 3'b010);
    end
    applyStimulus("t3_oneshot_done", 1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 0, 3'b001);
    applyStimulus("t3_idle", 1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // Sanitising: P=0,H=0 -> 2/1; then P=6,H=9 loaded on a wrap edge -> 6/5
    applyStimulus("t4_load0", 1'b0, 2'b00, 1'b0, 1'b1, 0, 0, 0, 3'b000);
    applyStimulus("t4_p2", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    applyStimulus("t4_p2", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b010);
    applyStimulus("t4_wrapload", 1'b1, 2'b00, 1'b0, 1'b1, 6, 9, 1, 3'b110);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("t4_h5", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    end
    applyStimulus("t4_low", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b010);
    applyStimulus("t4_wrap", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    applyStimulus("t4_stop", 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // Abort a 5-pulse burst in its second period, then a full restart
    applyStimulus("t5_load", 1'b1, 2'b10, 1'b0, 1'b1, 4, 1, 5, 3'b000);
    for (int i = 0; i < 6; i++) begin
      applyStimulus("t5_pre_abort", 1'b1, 2'b10, (i == 0), 1'b0, 0, 0, 0,
                    {((i % 4) < 1), 1'b1, 1'b0});
    end
    applyStimulus("t5_abort", 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 3'b000);
    applyStimulus("t5_no_done", 1'b0, 2'b10, 1'b0, 1'b0, 0, 0, 0, 3'b000);
    runPeriods("t5_restart", 2'b10, 4, 1, 5, 1'b1);
    applyStimulus("t5_done", 1'b1, 2'b10, 1'b0, 1'b0, 0, 0, 0, 3'b001);
    applyStimulus("t5_idle", 1'b1, 2'b10, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    // Async reset mid-pulse, then defaults must be back
    applyStimulus("t6_load", 1'b0, 2'b00, 1'b0, 1'b1, 3, 2, 1, 3'b000);
    applyStimulus("t6_start", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    @(negedge clk);
    #1;
    checkOutput("t6_pre_reset", {29'd0, pulse, busy, done}, 32'd6);
    reset = 1'b0;
    #1;
    checkOutput("t6_async_reset", {29'd0, pulse, busy, done}, 32'd0);
    enable = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("t6_reset_hold", {29'd0, pulse, busy, done}, 32'd0);
    reset = 1'b1;
    runPeriods("t6_default", 2'b00, 10, 1, 1, 1'b0);
    applyStimulus("t6_default_wrap", 1'b1, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b110);
    applyStimulus("t6_stop", 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 3'b000);

    @(posedge clk);
    #2;
    checkOutput("sb_drain", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
